bresenham_ray_ctrl: RTL and testbench
=====================================

# bresenham_ray_ctrl

- Sequences one Bresenham ray across the occupancy grid.
- Accepts a start cell and an end cell, then emits every traversed grid cell, one per cycle, on a valid/ready stream.
- Classifies the octant once per ray (x-negate, y-negate, axis-swap), steps in the normalised first octant, and maps each step back to grid indices.
- Sits between the scan-point projection stage and the map-update unit.

## Interface
- `X_WIDTH`, default 8: grid column index width.
- `Y_WIDTH`, default 7: grid row index width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start_valid`  in  1  ray request.
- `start_ready`  out  1  high only in IDLE; request accepted when `start_valid && start_ready`.
- `x0`  in  `X_WIDTH`  ray origin column; sampled on accept.
- `y0`  in  `Y_WIDTH`  ray origin row; sampled on accept.
- `x1`  in  `X_WIDTH`  ray end column; sampled on accept.
- `y1`  in  `Y_WIDTH`  ray end row; sampled on accept.
- `cell_x`  out  `X_WIDTH`  emitted cell column.
- `cell_y`  out  `Y_WIDTH`  emitted cell row.
- `cell_valid`  out  1  emitted cell valid.
- `cell_ready`  in  1  consumer accepts cell.
- `cell_last`  out  1  qualifies the final cell of the ray.
- `busy`  out  1  high in SETUP and STEP.
- `done`  out  1  one-cycle pulse when the ray completes.

## Operation
- **FSM states:** IDLE, SETUP, STEP.
- **IDLE → SETUP** on start handshake. Latch `x0`, `y0`, `x1`, `y1`.
- **SETUP (one cycle):**
  - `dx = x1 - x0`, signed, `X_WIDTH+1` bits; `dy = y1 - y0`, signed, `Y_WIDTH+1` bits.
  - `sx = dx<0`, `sy = dy<0`, `ax = |dx|`, `ay = |dy|`.
  - `swap = ay > ax`. Ties do not swap.
  - Major `M = swap ? ay : ax`; minor `m = swap ? ax : ay`.
  - `err = 2m - M`, signed, `max(X_WIDTH,Y_WIDTH)+3` bits.
  - `u = 0`, `v = 0`.
  - Go to STEP. With `RAY_EXCLUDE_ENDPOINT_EN` and `M == 0`, go directly to IDLE and pulse `done`.
- **STEP, cell mapping:**
  - `!swap`: `cell_x = x0 + (sx ? -u : u)`, `cell_y = y0 + (sy ? -v : v)`.
  - `swap`: `cell_x = x0 + (sx ? -v : v)`, `cell_y = y0 + (sy ? -u : u)`.
  - Sums truncate modulo 2^width. In-range endpoints never wrap.
- **STEP, advance on output handshake:**
  - If `err > 0` (strict): `v += 1`, `err += 2(m - M)`.
  - Else: `err += 2m`.
  - Always `u += 1`.
- **Last cell:** `cell_last = (u == M)`. The handshake on the last cell returns the FSM to IDLE and pulses `done`.
- **Cell count:** `M + 1` cells emitted, both endpoints included. `M == 0` emits exactly the origin cell with `cell_last = 1`.
- **Start requests:** `start_valid` outside IDLE is ignored, since `start_ready = 0`.

## Timing
- All outputs are registered.
- **Reset values:** `start_ready = 1`, `cell_valid = 0`, `cell_last = 0`, `busy = 0`, `done = 0`, `cell_x = 0`, `cell_y = 0`. FSM = IDLE.
- **Reset mid-ray:** abandons the ray in the next cycle. No further cells, no `done` pulse.
- **Latency:** accept at cycle N; SETUP at N+1; first `cell_valid` at N+2.
- **Throughput:** one cell per cycle while `cell_ready = 1`. The next cell is presented in the cycle after each handshake.
- **Backpressure:** while `cell_valid && !cell_ready`, `cell_x`, `cell_y` and `cell_last` hold stable and internal state is frozen.
- **Done and next accept:** `done` is asserted in the cycle after the last handshake, and `start_ready` rises in that same cycle. The earliest next accept is therefore last handshake + 1.
- **Ray duration:** an `M`-major ray occupies `M + 3` cycles from accept to `done`, with zero backpressure.

## Configuration
- **`RAY_EXCLUDE_ENDPOINT_EN` defined:**
  - `cell_last = (u == M - 1)`; emits `M` cells, with the end cell omitted (free-space ray).
  - `M == 0` emits nothing; `done` pulses at accept + 2.
- **Undefined:** behaviour as above; end cell included, `M + 1` cells.

## Test plan
- (0,0)→(4,2), ready held high → cells (0,0),(1,0),(2,1),(3,1),(4,2). `cell_last` on the 5th cell; `done` at accept + 7.
- (10,20)→(8,27), swap with negated x → 8 cells. First (10,20), last (8,27). Y strictly increments by 1 per cell.
- (5,5)→(5,5) → single cell (5,5) with `cell_last = 1`. With the macro defined: no cells, `done` at accept + 2.
- (0,0)→(7,7) with `cell_ready` toggled 1,0,0,1… → outputs hold during stalls. Sequence (i,i) for i = 0..7 is unchanged.
- `start_valid` asserted during a ray → ignored. Second ray accepted exactly one cycle after `done`.
- `reset` asserted mid-ray on the 3rd cell → next cycle `cell_valid = 0`, `busy = 0`, `start_ready = 1`, no `done`.

Source files
------------

// File: rtl/bresenham_ray_ctrl.sv
// bresenham_ray_ctrl
//
// Walks one Bresenham ray from a start cell to an end cell and streams every
// traversed grid cell, one per cycle, on a valid/ready interface. The octant
// is classified once per ray (x-negate, y-negate, axis-swap). Stepping runs
// in the normalised first octant, and each step is mapped back to grid indices.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   start_valid/start_ready ray request handshake (ready only in idle)
//   x0, y0, x1, y1          ray origin and end cell, sampled on accept
//   cell_x, cell_y          emitted cell indices
//   cell_valid/cell_ready   output cell handshake
//   cell_last               marks the final cell of the ray
//   busy                    high while a ray is being set up or stepped
//   done                    one-cycle pulse after the final handshake
//
// Build option: define RAY_EXCLUDE_ENDPOINT_EN to omit the end cell, which
// gives a free-space ray of M cells. A zero-length ray then emits nothing.
// All outputs are registered.

module bresenham_ray_ctrl #(
  parameter int unsigned X_WIDTH = 8,
  parameter int unsigned Y_WIDTH = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [X_WIDTH-1:0] x0,
  input  logic [Y_WIDTH-1:0] y0,
  input  logic [X_WIDTH-1:0] x1,
  input  logic [Y_WIDTH-1:0] y1,
  output logic [X_WIDTH-1:0] cell_x,
  output logic [Y_WIDTH-1:0] cell_y,
  output logic               cell_valid,
  input  logic               cell_ready,
  output logic               cell_last,
  output logic               busy,
  output logic               done
);

  localparam int unsigned W  = (X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH;
  localparam int unsigned EW = W + 3;

  typedef enum logic [1:0] {StIdle, StSetup, StStep} state_e;

  state_e state_q, state_d;

  logic [X_WIDTH-1:0] x0_q, x0_d, x1_q, x1_d;
  logic [Y_WIDTH-1:0] y0_q, y0_d, y1_q, y1_d;
  logic               sx_q, sx_d, sy_q, sy_d, swap_q, swap_d;
  logic [W-1:0]       maj_q, maj_d, min_q, min_d;
  logic [W-1:0]       u_q, u_d, v_q, v_d;
  logic signed [EW-1:0] err_q, err_d;

  logic               start_ready_q, start_ready_d;
  logic               cell_valid_q, cell_valid_d;
  logic               cell_last_q, cell_last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [X_WIDTH-1:0] cell_x_q, cell_x_d;
  logic [Y_WIDTH-1:0] cell_y_q, cell_y_d;

  // Octant classification from the latched endpoints.
  logic signed [X_WIDTH:0] dx, adx;
  logic signed [Y_WIDTH:0] dy, ady;
  logic [W-1:0]            ax, ay, s_maj, s_min;
  logic                    s_sx, s_sy, s_swap;
  logic signed [EW-1:0]    s_err;

  always_comb begin
    dx     = $signed({1'b0, x1_q}) - $signed({1'b0, x0_q});
    dy     = $signed({1'b0, y1_q}) - $signed({1'b0, y0_q});
    s_sx   = dx[X_WIDTH];
    s_sy   = dy[Y_WIDTH];
    adx    = s_sx ? -dx : dx;
    ady    = s_sy ? -dy : dy;
    // The magnitudes are at most 2^width - 1, so the sign bit of adx/ady is always clear.
    ax     = W'($unsigned(adx));
    ay     = W'($unsigned(ady));
    s_swap = ay > ax;  // ties stay x-major
    s_maj  = s_swap ? ay : ax;
    s_min  = s_swap ? ax : ay;
    s_err  = $signed({2'b00, s_min, 1'b0}) - $signed({3'b000, s_maj});
  end

  // Error increments for the two step kinds: 2m and 2(m - M).
  logic signed [EW-1:0] min2, dif2;
  logic                 err_pos;

  assign min2    = $signed({2'b00, min_q, 1'b0});
  assign dif2    = min2 - $signed({2'b00, maj_q, 1'b0});
  assign err_pos = !err_q[EW-1] && (err_q != '0);

  function automatic logic [X_WIDTH-1:0] map_x(logic [X_WIDTH-1:0] org, logic neg,
                                               logic [W-1:0] step);
    logic [X_WIDTH-1:0] s;
    s = X_WIDTH'(step);
    return neg ? org - s : org + s;
  endfunction

  function automatic logic [Y_WIDTH-1:0] map_y(logic [Y_WIDTH-1:0] org, logic neg,
                                               logic [W-1:0] step);
    logic [Y_WIDTH-1:0] s;
    s = Y_WIDTH'(step);
    return neg ? org - s : org + s;
  endfunction

  always_comb begin
    state_d      = state_q;
    x0_d         = x0_q;
    y0_d         = y0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    swap_d       = swap_q;
    maj_d        = maj_q;
    min_d        = min_q;
    u_d          = u_q;
    v_d          = v_q;
    err_d        = err_q;
    cell_valid_d = cell_valid_q;
    cell_last_d  = cell_last_q;
    cell_x_d     = cell_x_q;
    cell_y_d     = cell_y_q;
    done_d       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_valid) begin
          x0_d    = x0;
          y0_d    = y0;
          x1_d    = x1;
          y1_d    = y1;
          state_d = StSetup;
        end
      end

      StSetup: begin
        sx_d     = s_sx;
        sy_d     = s_sy;
        swap_d   = s_swap;
        maj_d    = s_maj;
        min_d    = s_min;
        err_d    = s_err;
        u_d      = '0;
        v_d      = '0;
        cell_x_d = x0_q;
        cell_y_d = y0_q;
`ifdef RAY_EXCLUDE_ENDPOINT_EN
        if (s_maj == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          state_d      = StStep;
          cell_valid_d = 1'b1;
          cell_last_d  = (s_maj == W'(1));
        end
`else
        state_d      = StStep;
        cell_valid_d = 1'b1;
        cell_last_d  = (s_maj == '0);
`endif
      end

      StStep: begin
        // Without a handshake, every register holds its value, which freezes the output.
        if (cell_valid_q && cell_ready) begin
          if (cell_last_q) begin
            state_d      = StIdle;
            cell_valid_d = 1'b0;
            cell_last_d  = 1'b0;
            done_d       = 1'b1;
          end else begin
            u_d = u_q + W'(1);
            if (err_pos) begin
              v_d   = v_q + W'(1);
              err_d = err_q + dif2;
            end else begin
              err_d = err_q + min2;
            end
            cell_x_d = map_x(x0_q, sx_q, swap_q ? v_d : u_d);
            cell_y_d = map_y(y0_q, sy_q, swap_q ? u_d : v_d);
`ifdef RAY_EXCLUDE_ENDPOINT_EN
            cell_last_d = (u_d == maj_q - W'(1));
`else
            cell_last_d = (u_d == maj_q);
`endif
          end
        end
      end

      default: state_d = StIdle;
    endcase

    start_ready_d = (state_d == StIdle);
    busy_d        = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      x0_q          <= '0;
      y0_q          <= '0;
      x1_q          <= '0;
      y1_q          <= '0;
      sx_q          <= 1'b0;
      sy_q          <= 1'b0;
      swap_q        <= 1'b0;
      maj_q         <= '0;
      min_q         <= '0;
      u_q           <= '0;
      v_q           <= '0;
      err_q         <= '0;
      start_ready_q <= 1'b1;
      cell_valid_q  <= 1'b0;
      cell_last_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      cell_x_q      <= '0;
      cell_y_q      <= '0;
    end else begin
      state_q       <= state_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
      x1_q          <= x1_d;
      y1_q          <= y1_d;
      sx_q          <= sx_d;
      sy_q          <= sy_d;
      swap_q        <= swap_d;
      maj_q         <= maj_d;
      min_q         <= min_d;
      u_q           <= u_d;
      v_q           <= v_d;
      err_q         <= err_d;
      start_ready_q <= start_ready_d;
      cell_valid_q  <= cell_valid_d;
      cell_last_q   <= cell_last_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      cell_x_q      <= cell_x_d;
      cell_y_q      <= cell_y_d;
    end
  end

  assign start_ready = start_ready_q;
  assign cell_valid  = cell_valid_q;
  assign cell_last   = cell_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cell_x      = cell_x_q;
  assign cell_y      = cell_y_q;

endmodule

// File: tb/tb_bresenham_ray_ctrl.sv
// Testbench for bresenham_ray_ctrl: directed and random rays, with each ray
// compared against an integer line-walk model. The bench also checks latency,
// the done pulse, back-to-back accepts, stall holding and a reset in mid-ray.

module tb_bresenham_ray_ctrl;

  localparam int XW = 8;
  localparam int YW = 7;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_valid;
  logic          start_ready;
  logic [XW-1:0] x0, x1, cell_x;
  logic [YW-1:0] y0, y1, cell_y;
  logic          cell_valid, cell_ready, cell_last, busy, done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bresenham_ray_ctrl #(
    .X_WIDTH(XW),
    .Y_WIDTH(YW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_valid(start_valid),
    .start_ready(start_ready),
    .x0         (x0),
    .y0         (y0),
    .x1         (x1),
    .y1         (y1),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_last  (cell_last),
    .busy       (busy),
    .done       (done)
  );

  typedef logic [XW+YW:0] cell_t;  // {last, x, y}
  cell_t exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference line walk in plain integers. Cells are listed from the origin to the end point.
  task automatic build_exp(input int ax0, input int ay0, input int ax1, input int ay1);
    int    ddx, ddy, stx, sty, adx, ady, maj, mn, e, x, y;
    bit    sw;
    cell_t c;
    exp_q.delete();
    ddx = ax1 - ax0;
    ddy = ay1 - ay0;
    stx = (ddx < 0) ? -1 : 1;
    sty = (ddy < 0) ? -1 : 1;
    adx = (ddx < 0) ? -ddx : ddx;
    ady = (ddy < 0) ? -ddy : ddy;
    sw  = ady > adx;
    maj = sw ? ady : adx;
    mn  = sw ? adx : ady;
    e   = 2 * mn - maj;
    x   = ax0;
    y   = ay0;
    for (int i = 0; i <= maj; i++) begin
      exp_q.push_back({1'b0, XW'(x), YW'(y)});
      if (e > 0) begin
        if (sw) x += stx;
        else y += sty;
        e += 2 * (mn - maj);
      end else begin
        e += 2 * mn;
      end
      if (sw) y += sty;
      else x += stx;
    end
`ifdef RAY_EXCLUDE_ENDPOINT_EN
    void'(exp_q.pop_back());
`endif
    if (exp_q.size() > 0) begin
      c = exp_q.pop_back();
      c[XW+YW] = 1'b1;
      exp_q.push_back(c);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int k);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (k % 3) == 0;
    return $urandom_range(0, 3) != 0;
  endfunction

  // The caller is at a negedge in which start_ready is expected high. The task
  // returns at the negedge of the done cycle, so a next ray can be issued immediately.
  task automatic run_ray(input int ax0, input int ay0, input int ax1, input int ay1,
                         input int rmode, input bit stray, input string tag);
    int    acc, stalls, idx, k, budget, first_cyc;
    bit    held_pend, got_done;
    cell_t held, obs;
    build_exp(ax0, ay0, ax1, ay1);
    check({tag, " start_ready"}, 32'(start_ready), 32'd1);
    start_valid = 1'b1;
    x0 = XW'(ax0);
    y0 = YW'(ay0);
    x1 = XW'(ax1);
    y1 = YW'(ay1);
    acc = cyc;
    @(negedge clk);
    // The endpoints were latched on accept, so later changes must have no effect.
    start_valid = stray;
    x0 = XW'($urandom);
    y0 = YW'($urandom);
    x1 = XW'($urandom);
    y1 = YW'($urandom);
    idx = 0; k = 0; stalls = 0; first_cyc = -1; held_pend = 0; got_done = 0;
    held = '0;
    budget = 4 * exp_q.size() + 20;
    while (!got_done && budget > 0) begin
      if (done) begin
        got_done = 1;
      end else begin
        obs = {cell_last, cell_x, cell_y};
        if (cell_valid) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (held_pend) check({tag, " hold"}, 32'(obs), 32'(held));
        end
        held_pend  = 0;
        cell_ready = ready_pat(rmode, k);
        k++;
        if (cell_valid) begin
          if (cell_ready) begin
            if (idx < exp_q.size()) check($sformatf("%s cell%0d", tag, idx), 32'(obs),
                                          32'(exp_q[idx]));
            idx++;
          end else begin
            stalls++;
            held      = obs;
            held_pend = 1;
          end
        end
        budget--;
        @(negedge clk);
      end
    end
    check({tag, " done seen"}, 32'(got_done), 32'd1);
    check({tag, " cell count"}, 32'(idx), 32'(exp_q.size()));
    check({tag, " done cycle"}, 32'(cyc), 32'(acc + 2 + exp_q.size() + stalls));
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    if (exp_q.size() > 0) check({tag, " first cell cycle"}, 32'(first_cyc), 32'(acc + 2));
  endtask

  initial begin
    int rx0, ry0, rx1, ry1, acc;
    bit seen_bad;
    reset = 1'b1;
    start_valid = 1'b0;
    cell_ready = 1'b0;
    x0 = '0; y0 = '0; x1 = '0; y1 = '0;
    repeat (3) @(negedge clk);
    check("reset outputs", 32'({start_ready, cell_valid, cell_last, busy, done, cell_x, cell_y}),
          32'({1'b1, 4'b0000, XW'(0), YW'(0)}));
    reset = 1'b0;
    @(negedge clk);

    run_ray(0, 0, 4, 2, 0, 1'b0, "shallow");
    run_ray(10, 20, 8, 27, 0, 1'b0, "steep_negx");
    run_ray(5, 5, 5, 5, 0, 1'b0, "point");
    run_ray(0, 0, 7, 7, 1, 1'b0, "diag_stall");
    run_ray(3, 60, 200, 2, 0, 1'b1, "stray_start");
    run_ray(100, 100, 90, 10, 2, 1'b0, "back_to_back");
    for (int r = 0; r < 25; r++) begin
      rx0 = $urandom_range(0, 255);
      ry0 = $urandom_range(0, 127);
      rx1 = $urandom_range(0, 255);
      ry1 = $urandom_range(0, 127);
      run_ray(rx0, ry0, rx1, ry1, $urandom_range(0, 2), 1'($urandom_range(0, 1)),
              $sformatf("rand%0d", r));
    end
    start_valid = 1'b0;
    cell_ready  = 1'b1;
    @(negedge clk);

    // Reset while the third cell of (0,0)->(7,7) is presented.
    start_valid = 1'b1;
    x0 = '0; y0 = '0; x1 = XW'(7); y1 = YW'(7);
    acc = cyc;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("reset test third cell", 32'(cyc - acc), 32'd4);
    check("third cell value", 32'({cell_valid, cell_x, cell_y}), 32'({1'b1, XW'(2), YW'(2)}));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid-ray reset outputs", 32'({cell_valid, busy, start_ready, done}), 32'b0010);
    seen_bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cell_valid || done || busy) seen_bad = 1'b1;
    end
    check("quiet after reset", 32'(seen_bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
